// File: rtl/rr_mux_pkg.sv
// Shared arbitration definitions: mode encodings and the select-index width helper
// used by rr_mux and the other arbiters in the core.
package rr_mux_pkg;

  localparam int ARB_FIXED = 32'sd0;
  localparam int ARB_RR    = 32'sd1;

  // Index width for an n-way select; a single channel still needs one bit.
  function automatic int sel_width(input int n);
    if (n <= 32'sd1) begin
      return 32'sd1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way arbiter: round-robin from a rotating pointer or fixed lowest-index priority.
// Grant is combinational; the pointer advances only when the caller reports a transfer.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int RR   = ARB_RR,
  localparam int SELW = sel_width(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] gnt_idx
);

  logic [SELW-1:0] ptr_r;
  logic [N-1:0]    gnt_s;
  logic [SELW-1:0] gnt_idx_s;

  // Scan requests starting at the pointer (or at 0 in fixed mode) and grant the first hit.
  always_comb begin : scan
    int   start;
    int   pos;
    logic found;
    logic hit;
    gnt_s     = '0;
    gnt_idx_s = '0;
    found     = 1'b0;
    hit       = 1'b0;
    pos       = 32'sd0;
    start     = (RR == ARB_RR) ? int'(ptr_r) : 32'sd0;
    for (int k = 0; k < N; k++) begin
      pos        = (start + k) % N;
      hit        = !found && req[pos];
      gnt_s[pos] = gnt_s[pos] | hit;
      gnt_idx_s  = hit ? SELW'(pos) : gnt_idx_s;
      found      = found | hit;
    end
  end

  // Pointer moves just past the channel that transferred, wrapping at N-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if ((RR == ARB_RR) && (N > 32'sd1) && advance) begin
      ptr_r <= (gnt_idx_s == SELW'(N - 1)) ? '0 : gnt_idx_s + SELW'(1);
    end
  end

  assign gnt     = gnt_s;
  assign gnt_idx = gnt_idx_s;

endmodule

// File: rtl/rr_mux_checker.sv
// Structural invariants of the arbitrated mux: grant and accept are each at most
// one-hot and never point at a channel that is not offering a word.
module rr_mux_checker #(
  parameter int N = 4
) (
  input logic         clk,
  input logic         rst_n,
  input logic [N-1:0] in_valid,
  input logic [N-1:0] gnt,
  input logic [N-1:0] in_ready
);

  // Sample the invariants on every rising edge outside reset.
  always @(posedge clk) begin
    if (rst_n) begin
      assert ($onehot0(gnt));
      assert ($onehot0(in_ready));
      assert ((gnt & ~in_valid) == '0);
      assert ((in_ready & ~gnt) == '0);
    end
  end

endmodule

// File: rtl/rr_mux.sv
// N-channel valid/ready mux with a single registered output stage; arbitration is
// delegated to rr_arbiter, which advances only on an actual transfer.
module rr_mux
  import rr_mux_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  parameter  int RR    = ARB_RR,
  localparam int SELW  = sel_width(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [N-1:0]     gnt_s;
  logic [SELW-1:0]  gnt_idx_s;
  logic             load_s;
  logic             transfer_s;
  logic [WIDTH-1:0] sel_data_s;

  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic [SELW-1:0]  out_sel_r;

  rr_arbiter #(
    .N  (N),
    .RR (RR)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (in_valid),
    .advance (transfer_s),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  // The register can take a word when empty or when its word leaves this cycle.
  always_comb begin
    load_s     = !out_valid_r || out_ready;
    in_ready   = load_s ? gnt_s : '0;
    transfer_s = |(in_valid & in_ready);
    sel_data_s = in_data[gnt_idx_s * WIDTH +: WIDTH];
  end

  // Output stage: capture on transfer, go empty on a load slot with nothing to take.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sel_r   <= '0;
    end else if (load_s) begin
      out_valid_r <= transfer_s;
      if (transfer_s) begin
        out_data_r <= sel_data_s;
        out_sel_r  <= gnt_idx_s;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_sel   = out_sel_r;

  rr_mux_checker #(
    .N (N)
  ) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .gnt      (gnt_s),
    .in_ready (in_ready)
  );

endmodule

// File: doc/rr_mux.md
# rr_mux

Parametrised N-channel, registered successor to the two-input datapath mux: arbitrates among N valid/ready source channels and forwards one word per cycle into a single output register. Used wherever several producers share one downstream port (memory request port, writeback bus, debug/CSR access path). Supports round-robin or fixed-priority arbitration and applies backpressure to every source.

## Interface

Parameters:
- WIDTH, 32, data width of every channel and of the output
- N, 4, number of source channels (N ≥ 1)
- RR, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (lowest index wins)

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N  channel i offers a word
- in_ready  output  N  channel i's word is accepted this cycle
- out_data  output  WIDTH  registered selected word
- out_sel  output  SELW  index of the channel that produced out_data; SELW = max(1, clog2(N))
- out_valid  output  1  out_data/out_sel hold a word
- out_ready  input  1  downstream accepts the output word

## Operation

- Output register: out_valid, out_data, out_sel. load = !out_valid || out_ready.
- Grant: one-hot over in_valid. RR=0: lowest index i with in_valid[i]. RR=1: first i with in_valid[i] scanning from ptr upward, wrapping at N-1 → 0.
- in_ready[i] = grant[i] && load. At most one in_ready high per cycle; none when no in_valid or when !load.
- Transfer on channel i: in_valid[i] && in_ready[i]. Register loads in_data slice i, out_sel ← i, out_valid ← 1.
- load with no transfer: out_valid ← 0 (data/sel may hold stale values; benches must not check them while out_valid=0).
- ptr (RR=1 only): after transfer on channel g, ptr ← (g+1) mod N; otherwise unchanged. RR=0: ptr unused, fixed 0.
- Source rules: in_valid must not depend on in_ready; a source holds valid and data stable until accepted. Grant may move to another channel while stalled; only valid&&ready constitutes a transfer.
- N=1: grant = in_valid[0]; out_sel constant 0; ptr stays 0.

## Timing

- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_sel=0, ptr=0; in_ready therefore follows grant immediately (load=1).
- Reset mid-operation discards any held output word; no source is considered accepted in the reset cycle.
- Latency: input word accepted in cycle t appears with out_valid=1 from cycle t+1.
- Throughput: one word per cycle with out_ready held high.
- Backpressure: out_valid && !out_ready → all in_ready low, output stable, ptr stable.
- in_ready is combinational from in_valid, ptr, out_valid, out_ready (no skid buffer; one-cycle ready path through this block is accepted).
- Simultaneous output drain and input accept in the same cycle: both occur; no bubble.
- Wrap-around: ptr = N-1 with grant to N-1 → ptr = 0.

## Structure

- Shared package: SELW computation function (clog2 with floor of 1) and arbitration-mode constants (ARB_FIXED=0, ARB_RR=1); reused by other arbiters in the core.
- Sub-module rr_arbiter: parameters N, RR; inputs clk, rst_n, req[N], advance; output gnt[N] one-hot and gnt_idx[SELW]; owns ptr. rr_mux instantiates it with advance = transfer and owns the output register and data selection.

## Test plan

- Reset: assert rst_n=0 mid-stream with out_valid=1 → out_valid=0, out_data=0, out_sel=0 immediately; first grant after release to channel 0 when all valid.
- Round-robin fairness (N=4, RR=1, all in_valid=1, out_ready=1) → out_sel sequence 0,1,2,3,0,1 on consecutive cycles, one word per cycle.
- Fixed priority (RR=0, all valid) → out_sel stays 0 each cycle; channel 2 only served after channel 0 and 1 drop valid.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with channels 1,3 valid → all in_ready=0, out_data/out_sel unchanged, ptr unchanged; on release word from next-granted channel appears the following cycle.
- Sparse/wrap: ptr=3, only channel 3 then only channel 0 valid → out_sel 3 then 0, ptr ends at 1; idle cycle with no valid → out_valid drops to 0.
- N=1, WIDTH=8: in_data=0xA5 streaming → out_data=0xA5 one cycle later, out_sel=0, in_ready tracks load.
